conbus_sched: RTL and testbench

Registered round-robin bus scheduler for the seven-master shared Wishbone interconnect. It takes the masters' CYC lines as requests and produces the one-hot grant that steers the shared master bus. Each grant is fairly rotated and capped by a per-tenure transfer quota, which is only enforced at burst boundaries. A watchdog flags a granted master whose strobe goes unacknowledged for too long.

---
 rtl/conbus_sched.sv | 162 ++++++++++++++++
 tb/tb_conbus_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/conbus_sched.sv
// rtl/conbus_sched.sv - registered round-robin grant scheduler with per-tenure quota and strobe watchdog
module conbus_sched #(
  parameter int unsigned N_MASTERS = 7,
  parameter int unsigned QUOTA     = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 bus_stb,
  input  logic [2:0]           bus_cti,
  input  logic                 bus_ack,
  output logic [N_MASTERS-1:0] gnt,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           err_id
);

  localparam int unsigned          QUOTA_M1 = (QUOTA == 0) ? 0 : QUOTA - 1;
  localparam int unsigned          TO_M1    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [2:0]           LAST_RST = 3'(N_MASTERS - 1);
  localparam logic [3:0]           N4       = 4'(N_MASTERS);
  localparam logic [N_MASTERS-1:0] ONE      = N_MASTERS'(1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t               state_q, state_d;
  logic [2:0]           last_q, last_d;
  logic [7:0]           xfer_cnt_q, xfer_cnt_d;
  logic [15:0]          wd_cnt_q, wd_cnt_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [2:0]           gnt_id_q, gnt_id_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [2:0]           err_id_q, err_id_d;

  logic       other_valid;
  logic [2:0] other_id;
  logic [3:0] j;
  logic       quota_hit, burst_close, stall, wd_fire;
  logic       grant_now;
  logic [2:0] new_id;

  // Scan last+1 .. last+N-1; iterating downwards leaves the nearest hit in other_id.
  always_comb begin
    other_valid = 1'b0;
    other_id    = 3'd0;
    j           = 4'd0;
    for (int k = N_MASTERS - 1; k >= 1; k--) begin
      j = {1'b0, last_q} + 4'(k);
      if (j >= N4) j = j - N4;
      if (req[j[2:0]]) begin
        other_valid = 1'b1;
        other_id    = j[2:0];
      end
    end
  end

  assign quota_hit   = (QUOTA != 0) && (32'(xfer_cnt_q) >= QUOTA_M1) && bus_ack;
  assign burst_close = (bus_cti == 3'b000) || (bus_cti == 3'b111);
  assign stall       = bus_stb & ~bus_ack;
  assign wd_fire     = (TIMEOUT != 0) && stall && (32'(wd_cnt_q) == TO_M1);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    xfer_cnt_d = xfer_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    err_id_d   = err_id_q;
    grant_now  = 1'b0;
    new_id     = 3'd0;

    case (state_q)
      S_IDLE: begin
        gnt_d      = '0;
        busy_d     = 1'b0;
        xfer_cnt_d = 8'd0;
        wd_cnt_d   = 16'd0;
        if (|req) begin
          grant_now = 1'b1;
          new_id    = other_valid ? other_id : last_q;
        end
      end
      S_OWN: begin
        if (!req[gnt_id_q]) begin
          if (other_valid) begin
            grant_now = 1'b1;
            new_id    = other_id;
          end else begin
            state_d    = S_IDLE;
            gnt_d      = '0;
            busy_d     = 1'b0;
            xfer_cnt_d = 8'd0;
            wd_cnt_d   = 16'd0;
          end
        end else if (quota_hit && burst_close && other_valid) begin
          grant_now = 1'b1;
          new_id    = other_id;
        end else begin
          if (bus_ack && xfer_cnt_q != 8'hFF) xfer_cnt_d = xfer_cnt_q + 8'd1;
          // Grant stays with the stalled master; only the error is reported.
          if (wd_fire) begin
            err_d    = 1'b1;
            err_id_d = gnt_id_q;
            wd_cnt_d = 16'd0;
          end else if (stall) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
          end else begin
            wd_cnt_d = 16'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_now) begin
      state_d    = S_OWN;
      gnt_d      = ONE << new_id;
      gnt_id_d   = new_id;
      last_d     = new_id;
      busy_d     = 1'b1;
      xfer_cnt_d = 8'd0;
      wd_cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      xfer_cnt_q <= 8'd0;
      wd_cnt_q   <= 16'd0;
      gnt_q      <= '0;
      gnt_id_q   <= 3'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_id_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      xfer_cnt_q <= xfer_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign err_id = err_id_q;

endmodule

// File: tb/tb_conbus_sched.sv
// tb/tb_conbus_sched.sv - directed-vector bench for conbus_sched (QUOTA=4, TIMEOUT=8)
module tb_conbus_sched;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [6:0] req;
  logic       bus_stb;
  logic [2:0] bus_cti;
  logic       bus_ack;
  logic [6:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       err;
  logic [2:0] err_id;

  int total = 0;
  int bad   = 0;

  conbus_sched #(
    .N_MASTERS (7),
    .QUOTA     (4),
    .TIMEOUT   (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .bus_stb   (bus_stb),
    .bus_cti   (bus_cti),
    .bus_ack   (bus_ack),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .err       (err),
    .err_id    (err_id)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change there too.
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic bus(input logic stb, input logic ack, input logic [2:0] cti);
    bus_stb = stb;
    bus_ack = ack;
    bus_cti = cti;
  endtask

  initial begin
    logic [6:0] exp_gnt;
    int         nxt;

    sys_rst_n = 1'b0;
    req       = 7'h7F;
    bus(1'b0, 1'b0, 3'b000);

    // Reset and first grant
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    sys_rst_n = 1'b1;
    step();
    chk("first_gnt", 32'(gnt), 32'h01);
    chk("first_gnt_id", 32'(gnt_id), 32'h0);
    chk("first_busy", 32'(busy), 32'h1);

    // Fairness: two acks per owner, then the owner drops CYC for one cycle
    for (int o = 0; o < 7; o++) begin
      exp_gnt = 7'(1 << o);
      for (int a = 0; a < 2; a++) begin
        bus(1'b1, 1'b1, 3'b000);
        step();
        chk($sformatf("fair_hold%0d", o), 32'(gnt), 32'(exp_gnt));
      end
      bus(1'b0, 1'b0, 3'b000);
      req = 7'h7F & ~exp_gnt;
      step();
      nxt = (o + 1) % 7;
      chk($sformatf("fair_next%0d", o), 32'(gnt), 32'(1 << nxt));
      chk($sformatf("fair_id%0d", o), 32'(gnt_id), 32'(nxt));
      chk($sformatf("fair_busy%0d", o), 32'(busy), 32'h1);
      req = 7'h7F;
    end

    // Quota with closing acks: switch after the 4th ack
    req = 7'h00;
    step();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_gnt", 32'(gnt), 32'h00);
    req = 7'h24;
    step();
    chk("q_own2", 32'(gnt), 32'h04);
    for (int a = 1; a <= 4; a++) begin
      bus(1'b1, 1'b1, 3'b000);
      step();
      chk($sformatf("q_ack%0d", a), 32'(gnt), (a == 4) ? 32'h20 : 32'h04);
    end
    chk("q_id5", 32'(gnt_id), 32'h5);

    // Quota inside a burst: switch only on the closing 7th ack
    bus(1'b0, 1'b0, 3'b000);
    req = 7'h00;
    step();
    req = 7'h24;
    step();
    chk("qb_own2", 32'(gnt), 32'h04);
    for (int a = 1; a <= 7; a++) begin
      bus(1'b1, 1'b1, (a >= 4 && a <= 6) ? 3'b010 : (a == 7) ? 3'b111 : 3'b000);
      step();
      chk($sformatf("qb_ack%0d", a), 32'(gnt), (a == 7) ? 32'h20 : 32'h04);
    end

    // Lone master keeps the grant past its quota
    bus(1'b0, 1'b0, 3'b000);
    req = 7'h00;
    step();
    req = 7'h08;
    step();
    chk("lone_own3", 32'(gnt), 32'h08);
    for (int a = 1; a <= 20; a++) begin
      bus(1'b1, 1'b1, 3'b000);
      step();
      chk($sformatf("lone_ack%0d", a), 32'(gnt), 32'h08);
    end

    // Watchdog: stalled strobe pulses err every 8 cycles, grant untouched
    bus(1'b0, 1'b0, 3'b000);
    req = 7'h00;
    step();
    req = 7'h02;
    step();
    chk("wd_own1", 32'(gnt), 32'h02);
    bus(1'b1, 1'b0, 3'b000);
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("wd_err%0d", c), 32'(err), (c % 8 == 0) ? 32'h1 : 32'h0);
      if (c == 8) begin
        chk("wd_err_id", 32'(err_id), 32'h1);
        chk("wd_gnt", 32'(gnt), 32'h02);
      end
    end
    chk("wd_gnt_end", 32'(gnt), 32'h02);

    // Mid-operation asynchronous reset
    bus(1'b0, 1'b0, 3'b000);
    req = 7'h00;
    step();
    req = 7'h10;
    step();
    chk("mr_own4", 32'(gnt), 32'h10);
    bus(1'b1, 1'b1, 3'b010);
    step();
    step();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mr_gnt_async", 32'(gnt), 32'h00);
    chk("mr_busy_async", 32'(busy), 32'h0);
    chk("mr_err_id_async", 32'(err_id), 32'h0);
    bus(1'b0, 1'b0, 3'b000);
    step();
    chk("mr_gnt_held", 32'(gnt), 32'h00);
    sys_rst_n = 1'b1;
    req = 7'h10;
    step();
    chk("mr_regrant", 32'(gnt), 32'h10);
    chk("mr_regrant_id", 32'(gnt_id), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
